// File: rtl/buf_reader_if.sv
// Interface bundle for buf_reader: control handshake, buffer read port and head-word stream.
// The master modport is the reader; the slave modport is the surrounding environment.
interface buf_reader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 10,
    parameter int BUFFER_SIZE = 512
);
    localparam int ID_W = $clog2(NUM_COL) + 1;
    localparam int AW   = $clog2(BUFFER_SIZE);
    localparam int PW   = 2 * DATA_WIDTH;

    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [AW:0]          length;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [PW+ID_W-1:0]   rd_data;
    logic [PW-1:0]        data_out;
    logic [ID_W-1:0]      id_out;
    logic [AW-1:0]        addr_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, base_addr, length, rd_data, ready_in,
        output rd_en, rd_addr, data_out, id_out, addr_out, valid_out, busy, done
    );

    modport slave (
        output start, base_addr, length, rd_data, ready_in,
        input  rd_en, rd_addr, data_out, id_out, addr_out, valid_out, busy, done
    );
endinterface

// File: rtl/buf_reader.sv
// Streams a block of psum words out of a 1-cycle-latency buffer through a 2-entry skid FIFO.
// Read issue is throttled so buffered plus in-flight words never exceed the FIFO depth.
module buf_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 10,
    parameter int BUFFER_SIZE = 512
) (
    input  logic          clk,
    input  logic          rstn,
    buf_reader_if.master  bus
);
    localparam int ID_W = $clog2(NUM_COL) + 1;
    localparam int AW   = $clog2(BUFFER_SIZE);
    localparam int PW   = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [AW:0]      len_r;
    logic [AW:0]      rd_cnt_r;
    logic [AW:0]      acc_cnt_r;
    logic [AW-1:0]    rd_addr_r;
    logic [AW-1:0]    fl_addr_r;
    logic             fl_r;
    logic             done_r;
    logic [1:0]       cnt_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [PW-1:0]    fd_r [2];
    logic [ID_W-1:0]  fi_r [2];
    logic [AW-1:0]    fa_r [2];

    logic             rd_en_s;
    logic             pop_s;
    logic             push_s;
    logic [2:0]       occ_s;
    logic             last_rd_s;
    logic             last_acc_s;
    logic             start_go_s;
    logic             start_zero_s;
    logic [AW-1:0]    next_addr_s;

    assign start_go_s   = (state_r == IDLE) && bus.start && (bus.length != {(AW+1){1'b0}});
    assign start_zero_s = (state_r == IDLE) && bus.start && (bus.length == {(AW+1){1'b0}});
    assign pop_s        = (cnt_r != 2'd0) && bus.ready_in;
    // A read issued last cycle always lands in the FIFO this cycle.
    assign push_s       = fl_r;
    assign occ_s        = {1'b0, cnt_r} + {2'b00, fl_r} - {2'b00, pop_s};
    assign last_rd_s    = (rd_cnt_r == (len_r - (AW+1)'(1)));
    assign last_acc_s   = (acc_cnt_r == (len_r - (AW+1)'(1)));
    assign next_addr_s  = (rd_addr_r == AW'(BUFFER_SIZE - 1)) ? {AW{1'b0}} : (rd_addr_r + AW'(1));

    // Next-state and read-issue decode.
    always_comb begin
        state_s = state_r;
        rd_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_go_s) state_s = READ;
                else            state_s = IDLE;
            end
            READ: begin
                if (occ_s < 3'd2) begin
                    rd_en_s = 1'b1;
                    if (last_rd_s) state_s = DRAIN;
                    else           state_s = READ;
                end else begin
                    state_s = READ;
                end
            end
            DRAIN: begin
                if (pop_s && last_acc_s) state_s = IDLE;
                else                     state_s = DRAIN;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Read address, counters, in-flight tracking and completion pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_r <= {AW{1'b0}};
            fl_addr_r <= {AW{1'b0}};
            fl_r      <= 1'b0;
            len_r     <= {(AW+1){1'b0}};
            rd_cnt_r  <= {(AW+1){1'b0}};
            acc_cnt_r <= {(AW+1){1'b0}};
            done_r    <= 1'b0;
        end else begin
            fl_r   <= rd_en_s;
            done_r <= ((state_r == DRAIN) && pop_s && last_acc_s) || start_zero_s;
            if (rd_en_s) fl_addr_r <= rd_addr_r;
            if (start_go_s) begin
                rd_addr_r <= bus.base_addr;
                len_r     <= bus.length;
                rd_cnt_r  <= {(AW+1){1'b0}};
                acc_cnt_r <= {(AW+1){1'b0}};
            end else begin
                if (rd_en_s) begin
                    rd_addr_r <= next_addr_s;
                    rd_cnt_r  <= rd_cnt_r + (AW+1)'(1);
                end
                if (pop_s) acc_cnt_r <= acc_cnt_r + (AW+1)'(1);
            end
        end
    end

    // Two-entry FIFO holding returned words tagged with their source address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r    <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fd_r[i] <= {PW{1'b0}};
                fi_r[i] <= {ID_W{1'b0}};
                fa_r[i] <= {AW{1'b0}};
            end
        end else begin
            if (push_s) begin
                fd_r[wr_ptr_r] <= bus.rd_data[PW+ID_W-1:ID_W];
                fi_r[wr_ptr_r] <= bus.rd_data[ID_W-1:0];
                fa_r[wr_ptr_r] <= fl_addr_r;
                wr_ptr_r       <= ~wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign bus.rd_en     = rd_en_s;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.data_out  = fd_r[rd_ptr_r];
    assign bus.id_out    = fi_r[rd_ptr_r];
    assign bus.addr_out  = fa_r[rd_ptr_r];
    assign bus.valid_out = (cnt_r != 2'd0);
    assign bus.busy      = (state_r != IDLE);
    assign bus.done      = done_r;
endmodule

// File: tb/tb_buf_reader.sv
// Directed bench for buf_reader: table of readout scenarios plus hand-written
// length-zero and mid-readout reset sequences, against a buffer model of {addr*3, addr%10}.
module tb_buf_reader;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    buf_reader_if #(.DATA_WIDTH(16), .NUM_COL(10), .BUFFER_SIZE(512)) bus ();

    buf_reader #(.DATA_WIDTH(16), .NUM_COL(10), .BUFFER_SIZE(512)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] exp_word(input logic [8:0] a);
        logic [31:0] d;
        logic [4:0]  i;
        d = 32'(a) * 32'd3;
        i = 5'(a % 9'd10);
        return {d, i};
    endfunction

    // Buffer model: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= exp_word(bus.rd_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        logic [3:0]  mask;          // ready_in for cycle c is mask[c%4]
        int          restart_cyc;   // >0: pulse start with base 200 at that cycle
        logic [8:0]  exp_last_addr;
        logic [31:0] exp_last_data;
        logic [4:0]  exp_last_id;
        int          exp_span;      // cycles first->last accept, <0 = not checked
    } vec_t;

    task automatic run_stream(input vec_t v);
        int issued, accepted, first_rd, first_val, first_acc, last_acc;
        int done_cnt, done_cyc, max_occ, cyc;
        bit done_seen, stalled;
        logic [45:0] held;
        logic [36:0] ew;
        logic [8:0]  la;
        logic [31:0] ld;
        logic [4:0]  li;
        issued = 0; accepted = 0; first_rd = -1; first_val = -1; first_acc = -1;
        last_acc = -1; done_cnt = 0; done_cyc = -1; max_occ = 0; done_seen = 0;
        stalled = 0; held = '0; la = '0; ld = '0; li = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = v.base; bus.length = v.len;
        @(negedge clk);
        for (cyc = 0; cyc < 200 && !done_seen; cyc++) begin
            if (cyc > 0) @(negedge clk);
            bus.ready_in = v.mask[cyc % 4];
            if (v.restart_cyc > 0 && v.restart_cyc == cyc) begin
                bus.start = 1'b1; bus.base_addr = 9'd200; bus.length = 10'd3;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.rd_en) begin
                chk("rd_addr", bus.rd_addr, 64'((int'(v.base) + issued) % 512));
                if (first_rd < 0) first_rd = cyc;
                issued++;
            end
            if (stalled)
                chk("head_stable", {bus.valid_out, bus.addr_out, bus.data_out, bus.id_out}, {1'b1, held});
            if (bus.valid_out && first_val < 0) first_val = cyc;
            if (bus.valid_out && bus.ready_in) begin
                ew = exp_word(9'((int'(v.base) + accepted) % 512));
                chk("addr_out", bus.addr_out, 64'((int'(v.base) + accepted) % 512));
                chk("data_out", bus.data_out, ew[36:5]);
                chk("id_out", bus.id_out, ew[4:0]);
                la = bus.addr_out; ld = bus.data_out; li = bus.id_out;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                accepted++;
            end
            stalled = bus.valid_out && !bus.ready_in;
            held    = {bus.addr_out, bus.data_out, bus.id_out};
            if (issued - accepted > max_occ) max_occ = issued - accepted;
            if (bus.done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_seen = 1;
                chk("busy_at_done", bus.busy, 1'b0);
            end
        end
        chk("done_seen", done_seen, 1'b1);
        chk("done_after_last", 64'(done_cyc), 64'(last_acc + 1));
        chk("reads_issued", 64'(issued), 64'(v.len));
        chk("words_accepted", 64'(accepted), 64'(v.len));
        chk("first_valid_latency", 64'(first_val - first_rd), 64'd2);
        chk("max_outstanding_le2", (max_occ <= 2), 1'b1);
        chk("last_addr", la, v.exp_last_addr);
        chk("last_data", ld, v.exp_last_data);
        chk("last_id", li, v.exp_last_id);
        if (v.exp_span >= 0) chk("throughput_span", 64'(last_acc - first_acc), 64'(v.exp_span));
        @(negedge clk); #1;
        chk("done_one_cycle", bus.done, 1'b0);
        chk("idle_after", {bus.busy, bus.rd_en}, 2'b00);
    endtask

    vec_t vecs[5];
    int   acc;

    initial begin
        checks = 0; errors = 0;
        rstn = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.ready_in = 1'b0;
        bus.rd_data = '0;

        vecs[0] = '{9'd0,   10'd5, 4'b1111, 0, 9'd4,   32'd12,  5'd4, 4};
        vecs[1] = '{9'd510, 10'd4, 4'b1111, 0, 9'd1,   32'd3,   5'd1, 3};
        vecs[2] = '{9'd20,  10'd8, 4'b1001, 0, 9'd27,  32'd81,  5'd7, -1};
        vecs[3] = '{9'd100, 10'd1, 4'b1111, 0, 9'd100, 32'd300, 5'd0, 0};
        vecs[4] = '{9'd300, 10'd6, 4'b1010, 3, 9'd305, 32'd915, 5'd5, -1};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctrl", {bus.rd_en, bus.valid_out, bus.busy, bus.done}, 4'b0000);
        chk("reset_rd_addr", bus.rd_addr, 9'd0);
        chk("reset_head", {bus.addr_out, bus.data_out, bus.id_out}, 46'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int k = 0; k < 5; k++) run_stream(vecs[k]);

        // Zero-length start: no reads, done one cycle later, never busy.
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 9'd50; bus.length = 10'd0;
        #1;
        chk("len0_start_cycle", {bus.busy, bus.rd_en, bus.done}, 3'b000);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("len0_done", {bus.done, bus.busy, bus.rd_en}, 3'b100);
        @(negedge clk); #1;
        chk("len0_after", {bus.done, bus.busy, bus.rd_en}, 3'b000);

        // Reset mid-readout after three accepted words, then a clean restart.
        @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 9'd0; bus.length = 10'd10; bus.ready_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        acc = 0;
        for (int c = 0; c < 40 && acc < 3; c++) begin
            #1;
            if (bus.valid_out && bus.ready_in) acc++;
            if (acc < 3) @(negedge clk);
        end
        chk("abort_reached_3", 64'(acc), 64'd3);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {bus.rd_en, bus.valid_out, bus.busy, bus.done, bus.rd_addr, bus.addr_out, bus.data_out, bus.id_out},
            59'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_stream('{9'd100, 10'd3, 4'b1111, 0, 9'd102, 32'd306, 5'd2, 2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buf_reader.md
BUF_READER -- requirements
Module: buf_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, PE operand width; streamed psum word is 2*DATA_WIDTH bits.
REQ-002 SHALL have parameter NUM_COL, default 10, PE columns per row; ID_W = $clog2(NUM_COL)+1.
REQ-003 SHALL have parameter BUFFER_SIZE, default 512, buffer depth; AW = $clog2(BUFFER_SIZE).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a readout.
REQ-007 SHALL have port base_addr  input  AW  first buffer address, sampled with start.
REQ-008 SHALL have port length  input  AW+1  word count, 0..BUFFER_SIZE, sampled with start.
REQ-009 SHALL have port rd_en  output  1  buffer read strobe.
REQ-010 SHALL have port rd_addr  output  AW  buffer read address.
REQ-011 SHALL have port rd_data  input  2*DATA_WIDTH+ID_W  packed {psum, id}; valid exactly one cycle after rd_en.
REQ-012 SHALL have ports data_out  output  2*DATA_WIDTH, id_out  output  ID_W, addr_out  output  AW: psum, column id, source address of the head word.
REQ-013 SHALL have port valid_out  output  1  head word valid.
REQ-014 SHALL have port ready_in  input  1  consumer accepts head word.
REQ-015 SHALL have ports busy  output  1  readout in progress; done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE; busy high in READ and DRAIN only.
REQ-017 SHALL, in IDLE with start=1 and length>0, latch base_addr/length, clear counters, enter READ next cycle.
REQ-018 SHALL, on start with length=0, remain IDLE, issue no reads, pulse done the following cycle.
REQ-019 SHALL ignore start while busy; latched base_addr/length unchanged.
REQ-020 SHALL assert rd_en in READ only when (fifo count + reads in flight - pop this cycle) < 2.
REQ-021 SHALL increment rd_addr after each rd_en, wrapping BUFFER_SIZE-1 -> 0.
REQ-022 SHALL move READ -> DRAIN in the cycle the length-th rd_en issues; no rd_en in DRAIN or IDLE.
REQ-023 SHALL capture rd_data into a 2-entry FIFO; split as data = rd_data[MSB:ID_W], id = rd_data[ID_W-1:0], tagged with its read address.
REQ-024 SHALL drive valid_out = FIFO non-empty; head word visible on data_out/id_out/addr_out.
REQ-025 SHALL pop head only when valid_out && ready_in; head fields SHALL hold stable while valid_out && !ready_in.
REQ-026 SHALL never overflow the FIFO; simultaneous push and pop in one cycle keeps count unchanged.
REQ-027 SHALL, with ready_in held high, first assert valid_out exactly 2 cycles after first rd_en and sustain one word per clock.
REQ-028 SHALL, in DRAIN, pulse done for one cycle in the cycle after the length-th word is accepted and return to IDLE in that same cycle.
REQ-029 SHALL deliver words in address order with no duplication or loss under any ready_in pattern.

Reset
REQ-030 SHALL, on rstn low, asynchronously force IDLE, empty FIFO, in-flight count 0, rd_en/valid_out/busy/done = 0, rd_addr/addr_out/data_out/id_out = 0.
REQ-031 SHALL abort a readout when reset asserts mid-operation; any rd_data returning after reset release SHALL be discarded.

Verification
REQ-032 SHALL cover: base 0, length 5, ready_in=1, rd_data = {k*3, k%10} at addr k -> addresses 0..4 with data 0,3,6,9,12, ids 0..4, done pulse, 1 word/clk.
REQ-033 SHALL cover: base 510, length 4 -> rd_addr sequence 510,511,0,1; addr_out matches.
REQ-034 SHALL cover: length 8, ready_in toggled 1,0,0,1 repeating -> 8 words in order, head stable while stalled, max two reads outstanding+buffered.
REQ-035 SHALL cover: length 0 start -> no rd_en, done high one cycle later, busy stays 0.
REQ-036 SHALL cover: rstn pulled low after 3 of 10 words accepted -> all outputs 0 immediately, next start from base 100 restarts cleanly at 100.
REQ-037 SHALL cover: start re-asserted with new base while busy -> ignored; original sequence completes unchanged.
